// File: rtl/pi_digit_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pi_digit_sequencer_pkg
// Brief    : Shared types and default constants for the pi digit sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pi_digit_sequencer_pkg;

    localparam int unsigned c_INDEX_W      = 10;
    localparam int unsigned c_CNT_W        = 16;
    localparam int unsigned c_LOAD_W       = 5;
    localparam int unsigned c_DWELL_CYCLES = 1000;
    localparam int unsigned c_GAP_CYCLES   = 100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHOW  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pi_digit_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pi_digit_sequencer_if
// Brief    : Control, ROM and display signals of the pi digit sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pi_digit_sequencer_if
    import pi_digit_sequencer_pkg::*;
#(
    parameter int unsigned INDEX_W = c_INDEX_W
);
    logic                load;
    logic [c_LOAD_W-1:0] load_data;
    logic                run;
    logic                step;
    logic [INDEX_W-1:0]  rom_index;
    logic [3:0]          rom_code;
    logic [3:0]          digit_code;
    logic                digit_valid;
    logic                blank;
    logic                dp;
    logic                wrap;

    // master: the sequencer itself
    modport master (
        input  load, load_data, run, step, rom_code,
        output rom_index, digit_code, digit_valid, blank, dp, wrap
    );

    // slave: the surrounding control, ROM and display logic
    modport slave (
        output load, load_data, run, step, rom_code,
        input  rom_index, digit_code, digit_valid, blank, dp, wrap
    );
endinterface
`default_nettype wire

// File: rtl/pi_digit_sequencer_seq_timer.sv
`default_nettype none
// ============================================================================
// Module   : pi_digit_sequencer_seq_timer
// Brief    : Loadable saturating down-counter shared for dwell and gap timing.
// Revision : 1.0 - initial release
// ============================================================================
module pi_digit_sequencer_seq_timer
    import pi_digit_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = c_CNT_W
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_value,
    input  wire logic             i_enable,
    output logic      [CNT_W-1:0] o_count,
    output logic                  o_zero
);
    logic [CNT_W-1:0] r_count;
    logic             w_zero;

    assign w_zero = (r_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && !w_zero) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = w_zero;
endmodule
`default_nettype wire

// File: rtl/pi_digit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pi_digit_sequencer
// Brief    : Walks the pi digit ROM and drives the 7-segment decoder with
//            dwell, blank gap, free-run and single-step control.
// Revision : 1.0 - initial release
// ============================================================================
module pi_digit_sequencer
    import pi_digit_sequencer_pkg::*;
#(
    parameter int unsigned INDEX_W      = c_INDEX_W,
    parameter int unsigned DWELL_CYCLES = c_DWELL_CYCLES,
    parameter int unsigned GAP_CYCLES   = c_GAP_CYCLES,
    parameter int unsigned CNT_W        = c_CNT_W
) (
    input  wire logic              clk,
    input  wire logic              reset,
    pi_digit_sequencer_if.master   bus
);
    localparam logic [CNT_W-1:0] c_DWELL_PRESET = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_PRESET   =
        (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
    localparam logic             c_GAP_SHORT    = (GAP_CYCLES <= 1);
    localparam logic             c_GAP_BLANK    = (GAP_CYCLES != 0);

    seq_state_t         r_state;
    logic [INDEX_W-1:0] r_index;
    logic [3:0]         r_digit_code;
    logic               r_digit_valid;
    logic               r_blank;
    logic               r_dp;
    logic               r_wrap;

    logic [CNT_W-1:0]   w_timer_count;
    logic               w_timer_zero;
    logic               w_timer_load;
    logic [CNT_W-1:0]   w_timer_value;
    logic               w_timer_en;
    logic               w_enter_gap;
    logic               w_advance;

    assign w_enter_gap = ((r_state == ST_SHOW) && w_timer_zero && bus.run) ||
                         ((r_state == ST_HOLD) && (bus.run || bus.step));

    // The index steps on the edge that opens the final GAP cycle, so the
    // registered ROM has already captured the next digit when FETCH runs.
    assign w_advance = (w_enter_gap && c_GAP_SHORT) ||
                       ((r_state == ST_GAP) && (w_timer_count == CNT_W'(1)));

    assign w_timer_load  = !bus.load && ((r_state == ST_FETCH) || w_enter_gap);
    assign w_timer_value = (r_state == ST_FETCH) ? c_DWELL_PRESET : c_GAP_PRESET;
    assign w_timer_en    = !bus.load && ((r_state == ST_SHOW) || (r_state == ST_GAP));

    pi_digit_sequencer_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_timer_load),
        .i_load_value (w_timer_value),
        .i_enable     (w_timer_en),
        .o_count      (w_timer_count),
        .o_zero       (w_timer_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_digit_code  <= '0;
            r_digit_valid <= 1'b0;
            r_blank       <= 1'b1;
            r_dp          <= 1'b0;
            r_wrap        <= 1'b0;
        end else begin
            r_digit_valid <= 1'b0;
            r_wrap        <= 1'b0;
            if (bus.load) begin
                r_index <= {bus.load_data, r_index[INDEX_W-1:c_LOAD_W]};
                r_state <= ST_IDLE;
                r_blank <= 1'b1;
                r_dp    <= 1'b0;
            end else begin
                if (w_advance) begin
                    r_index <= r_index + 1'b1;
                    r_wrap  <= (r_index == '1);
                end
                case (r_state)
                    ST_IDLE: begin
                        r_blank <= 1'b1;
                        if (bus.run || bus.step) begin
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        r_state       <= ST_SHOW;
                        r_digit_code  <= bus.rom_code;
                        r_digit_valid <= 1'b1;
                        r_blank       <= 1'b0;
                        r_dp          <= (r_index == '0);
                    end
                    ST_SHOW: begin
                        if (w_timer_zero) begin
                            if (bus.run) begin
                                r_state <= ST_GAP;
                                r_blank <= c_GAP_BLANK;
                                r_dp    <= 1'b0;
                            end else begin
                                r_state <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (bus.run || bus.step) begin
                            r_state <= ST_GAP;
                            r_blank <= c_GAP_BLANK;
                            r_dp    <= 1'b0;
                        end
                    end
                    ST_GAP: begin
                        // Blank spans exactly the GAP cycles between digits.
                        if (w_timer_zero) begin
                            r_state <= ST_FETCH;
                            r_blank <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_blank <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.rom_index   = r_index;
    assign bus.digit_code  = r_digit_code;
    assign bus.digit_valid = r_digit_valid;
    assign bus.blank       = r_blank;
    assign bus.dp          = r_dp;
    assign bus.wrap        = r_wrap;
endmodule
`default_nettype wire

// File: tb/tb_pi_digit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pi_digit_sequencer
// Brief    : Self-checking bench for pi_digit_sequencer with a ROM model and a
//            digit-level reference (index -> ROM digit, period, blank, wrap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pi_digit_sequencer;
    localparam int c_DWELL = 4;
    localparam int c_GAP_A = 2;
    localparam int c_GAP_B = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [4:0] load_data;
    logic       run;
    logic       step;
    bit         sel;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] rom_mem [1024];

    always #5 clk = ~clk;

    pi_digit_sequencer_if bus_a ();
    pi_digit_sequencer_if bus_b ();

    assign bus_a.load = load;  assign bus_a.load_data = load_data;
    assign bus_a.run  = run;   assign bus_a.step      = step;
    assign bus_b.load = load;  assign bus_b.load_data = load_data;
    assign bus_b.run  = run;   assign bus_b.step      = step;

    always @(posedge clk) bus_a.rom_code <= rom_mem[bus_a.rom_index];
    always @(posedge clk) bus_b.rom_code <= rom_mem[bus_b.rom_index];

    pi_digit_sequencer #(
        .INDEX_W (10), .DWELL_CYCLES (c_DWELL), .GAP_CYCLES (c_GAP_A), .CNT_W (16)
    ) u_dut_a (
        .clk (clk), .reset (reset), .bus (bus_a)
    );

    pi_digit_sequencer #(
        .INDEX_W (10), .DWELL_CYCLES (c_DWELL), .GAP_CYCLES (c_GAP_B), .CNT_W (16)
    ) u_dut_b (
        .clk (clk), .reset (reset), .bus (bus_b)
    );

    // Observation mux: sel picks which instance the checks look at.
    logic       o_valid, o_blank, o_dp, o_wrap;
    logic [3:0] o_code;
    logic [9:0] o_index;
    assign o_valid = sel ? bus_b.digit_valid : bus_a.digit_valid;
    assign o_blank = sel ? bus_b.blank       : bus_a.blank;
    assign o_dp    = sel ? bus_b.dp          : bus_a.dp;
    assign o_wrap  = sel ? bus_b.wrap        : bus_a.wrap;
    assign o_code  = sel ? bus_b.digit_code  : bus_a.digit_code;
    assign o_index = sel ? bus_b.rom_index   : bus_a.rom_index;

    function automatic int gap_len();
        return sel ? c_GAP_B : c_GAP_A;
    endfunction

    function automatic int period();
        int g = gap_len();
        return 1 + c_DWELL + ((g > 0) ? g : 1);
    endfunction

    task automatic check_value(input string tag, input int unsigned actual,
                               input int unsigned expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic wait_digit(output int cycles, output int blanks, output int wraps);
        bit seen = 1'b0;
        cycles = 0; blanks = 0; wraps = 0;
        while (!seen && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (o_valid) seen = 1'b1;
            else begin
                blanks += int'(o_blank);
                wraps  += int'(o_wrap);
            end
        end
        if (!seen) check_value("digit_timeout", 0, 1);
    endtask

    // Negative expectations skip that particular comparison.
    task automatic expect_digit(input int unsigned idx, input int exp_cycles,
                                input int exp_blanks, input int exp_wraps);
        int cyc, blk, wrp;
        wait_digit(cyc, blk, wrp);
        check_value("digit_code", o_code, rom_mem[idx]);
        check_value("dp", o_dp, (idx == 0));
        check_value("rom_index", o_index, idx);
        check_value("blank_show", o_blank, 0);
        if (exp_cycles >= 0) check_value("digit_period", cyc, exp_cycles);
        if (exp_blanks >= 0) check_value("gap_blank_cycles", blk, exp_blanks);
        if (exp_wraps  >= 0) check_value("wrap_pulses", wrp, exp_wraps);
    endtask

    task automatic check_reset_state(input string tag);
        check_value({tag, "_code"},  o_code,  0);
        check_value({tag, "_valid"}, o_valid, 0);
        check_value({tag, "_blank"}, o_blank, 1);
        check_value({tag, "_dp"},    o_dp,    0);
        check_value({tag, "_wrap"},  o_wrap,  0);
        check_value({tag, "_index"}, o_index, 0);
    endtask

    task automatic load_index(input int unsigned idx);
        @(negedge clk); load = 1'b1; load_data = idx[4:0];
        @(negedge clk); load_data = idx[9:5];
        @(negedge clk); load = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    initial begin
        int pi_head[50] = '{3,1,4,1,5,9,2,6,5,3,5,8,9,7,9,3,2,3,8,4,6,2,6,4,3,
                            3,8,3,2,7,9,5,0,2,8,8,4,1,9,7,1,6,9,3,9,9,3,7,5,1};
        int unsigned s, r, idx;
        int hb, hv, hc, k;
        for (int i = 0; i < 1024; i++)
            rom_mem[i] = (i < 50) ? 4'(pi_head[i]) : 4'($urandom_range(0, 15));
        reset = 1'b1; load = 1'b0; load_data = '0; run = 1'b0; step = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset_a");
        reset = 1'b0;

        // Free run from index 0: 3,1,4,1,5 with a 2-cycle blank gap.
        run = 1'b1;
        expect_digit(0, 2, -1, -1);
        for (int j = 1; j <= 4; j++) expect_digit(j, period(), gap_len(), 0);
        run = 1'b0;

        // Single step at index 3, held indefinitely, then one more step.
        load_index(3);
        check_value("loaded_index", o_index, 3);
        check_value("load_blank", o_blank, 1);
        pulse_step();
        expect_digit(3, -1, -1, -1);
        hb = 0; hv = 0; hc = 0;
        repeat (20) begin
            @(negedge clk);
            hb += int'(o_blank); hv += int'(o_valid); hc += int'(o_code != rom_mem[3]);
        end
        check_value("hold_blank", hb, 0);
        check_value("hold_valid", hv, 0);
        check_value("hold_code_changes", hc, 0);
        pulse_step();
        expect_digit(4, -1, -1, -1);

        // Wrap from the last index back to 0.
        load_index(1023);
        check_value("loaded_index_max", o_index, 1023);
        run = 1'b1;
        expect_digit(1023, 2, -1, -1);
        expect_digit(0, period(), gap_len(), 1);

        // load in the middle of SHOW while running.
        repeat (2) @(negedge clk);
        r = $urandom_range(1, 31);
        load = 1'b1; load_data = r[4:0];
        @(negedge clk);
        load = 1'b0;
        check_value("midshow_load_blank", o_blank, 1);
        check_value("midshow_load_valid", o_valid, 0);
        check_value("midshow_load_index", o_index, r << 5);
        expect_digit(r << 5, 2, -1, -1);

        // Randomised loads, run and step against the digit-level model.
        for (int t = 0; t < 8; t++) begin
            run = 1'b0;
            s = (t == 0) ? 1021 : $urandom_range(0, 1023);
            k = $urandom_range(3, 5);
            load_index(s);
            if ((t == 0) || ($urandom_range(0, 1) == 0)) begin
                run = 1'b1;
                expect_digit(s, 2, -1, -1);
                for (int j = 1; j <= k; j++) begin
                    idx = (s + j) % 1024;
                    expect_digit(idx, period(), gap_len(), (idx == 0) ? 1 : 0);
                end
            end else begin
                pulse_step();
                expect_digit(s, 1, -1, -1);
                for (int j = 1; j <= k; j++) begin
                    repeat (c_DWELL + 1 + $urandom_range(0, 3)) @(negedge clk);
                    check_value("step_hold_valid", o_valid, 0);
                    pulse_step();
                    expect_digit((s + j) % 1024, -1, -1, -1);
                end
            end
        end
        run = 1'b0;

        // Zero-length gap on the second instance: no blank, period DWELL+2.
        sel = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("reset_b");
        reset = 1'b0;
        load_index(1);
        run = 1'b1;
        expect_digit(1, 2, -1, -1);
        for (int j = 2; j <= 6; j++) expect_digit(j, period(), 0, 0);
        run = 1'b0;

        // Reset while the gap timer is mid-count.
        sel = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        load_index(5);
        run = 1'b1;
        expect_digit(5, 2, -1, -1);
        repeat (c_DWELL) @(negedge clk);
        check_value("in_gap_blank", o_blank, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("reset_in_gap");
        reset = 1'b0;
        run = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pi_digit_sequencer.md
Name: pi_digit_sequencer

Overview:
Controller that sequences the 1024-entry pi digit ROM and feeds the 7-segment decoder. It owns the 10-bit digit index, which is loaded 5 bits at a time or advanced automatically. It issues ROM reads and holds each digit on the display for a programmable dwell time. It inserts a blank gap between digits so that repeated digits (e.g. "1 1") remain distinguishable, and it supports free-run and single-step modes.

Parameters:
INDEX_W, 10, ROM index width; wraps at 2^INDEX_W-1.
DWELL_CYCLES, 1000, clock cycles a digit is shown; legal range 1..65535.
GAP_CYCLES, 100, blank cycles between digits; legal range 0..65535; 0 means no gap.
CNT_W, 16, width of the dwell/gap timer.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
load  in  1  shift load_data into index: index <= {load_data, index[9:5]}
load_data  in  5  index bits loaded by load
run  in  1  level; free-run sequencing while high
step  in  1  single-cycle pulse; advance one digit while run low
rom_index  out  INDEX_W  address to digit ROM
rom_code  in  4  ROM data; registered ROM, 1-cycle latency
digit_code  out  4  code to 7-seg decoder
digit_valid  out  1  1-cycle pulse when a new digit_code is latched
blank  out  1  display blank request
dp  out  1  decimal point; high while showing index 0 (the "3.")
wrap  out  1  1-cycle pulse when index advances 1023 -> 0

Behaviour:
- Reset values: index=0, state IDLE, digit_code=0, digit_valid=0, blank=1, dp=0, wrap=0, timer=0. rom_index always equals index.
- Priority each cycle: reset > load > FSM.
- load in any state: shift into index, go to IDLE, blank=1, digit_valid=0. A 10-bit index takes two loads: low half first, then high half.
- IDLE: blank=1. If run or step -> FETCH.
- FETCH: exactly 1 cycle (covers ROM latency) -> SHOW.
- On entry to SHOW: digit_code<=rom_code, digit_valid=1 for that cycle, blank=0, dp=(index==0), timer<=DWELL_CYCLES-1.
- SHOW: timer decrements each cycle. At timer==0: if run -> GAP, else -> HOLD.
- HOLD: digit stays displayed (blank=0). run or step -> GAP.
- GAP: blank=1, dp=0, timer loaded GAP_CYCLES-1 on entry. At expiry: index<=index+1 -> FETCH.
  - If GAP_CYCLES==0, GAP lasts exactly 1 cycle and blank is not asserted; index advances in that cycle.
- Wrap: index 1023+1 -> 0 and wrap=1 for that cycle; no stall.
- Latency: run rises at edge N in IDLE -> FETCH at N+1 -> digit_code/digit_valid visible after edge N+2.
- Digit period in free-run: 1 + DWELL_CYCLES + max(GAP_CYCLES,1) cycles.
- step is ignored outside IDLE/HOLD. run and step together: run dominates. run falling mid-SHOW: finish dwell, then HOLD. run falling in GAP: complete GAP, advance, fetch, show, then HOLD.
- rom_code values >9 are passed through unmodified; the decoder handles them.
- Reset mid-operation returns to reset values on the next edge; no partial index update.

Decomposition:
- Shared package: state enum (IDLE, FETCH, SHOW, HOLD, GAP), INDEX_W, CNT_W, default DWELL/GAP constants.
- Sub-module seq_timer: loadable CNT_W down-counter with load value, enable and zero flag. It is shared for dwell and gap.
- The FSM and index register stay in pi_digit_sequencer.

Test Plan:
1. Reset then run=1, DWELL=4, GAP=2, ROM model of pi: digit_code sequence 3,1,4,1,5 with dp=1 only on the 3. digit_valid pulses 7 cycles apart, and blank=1 for 2 cycles between digits.
2. load 5'b00011 then load 5'b00000 (index=3), step pulse: digit_code=1 shown and held with blank=0 indefinitely. A second step yields 5 (index 4).
3. Load index 1023 (loads 5'h1F, 5'h1F), run: after digit 1023, wrap pulses once, index=0, next digit_code=3 with dp=1.
4. load asserted mid-SHOW with run=1: next cycle state IDLE, blank=1, index shifted. No digit_valid until a new FETCH completes.
5. GAP_CYCLES=0, run: consecutive "1" digits (index 1 and 3 region) show no blank cycle, and digit_valid period equals 1+DWELL+1.
6. reset asserted during GAP with timer mid-count: next cycle all outputs at reset values, and index=0.
